rr_arb2_4: RTL
==============

# rr_arb2_4

Round-robin arbiter and sequencer that shares a single 2:1 4-bit multiplexer datapath between two requesters, A and B. It owns the mux select line and a registered output stage with a valid/ready handshake. Each requester sends bursts of 4-bit beats. A burst cap prevents either side from starving the other. The block sits between two 4-bit producers and one downstream consumer.

## Interface
Parameters:
- WIDTH, 4, data width of each input and of Out
- MAXBURST, 4, maximum beats per grant (legal range 1..15)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; sampled on the rising edge of clk
- reqA  input  1  A has a beat on A
- lastA  input  1  beat on A is the last of its burst
- A  input  WIDTH  requester A data
- ackA  output  1  A beat accepted this cycle (combinational)
- reqB  input  1  B has a beat on B
- lastB  input  1  beat on B is the last of its burst
- B  input  WIDTH  requester B data
- ackB  output  1  B beat accepted this cycle (combinational)
- s  output  1  mux select, registered (0 = A, 1 = B)
- Out  output  WIDTH  registered output data
- out_valid  output  1  Out holds a beat
- out_ready  input  1  consumer accepts Out this cycle

## Operation
- Internal datapath: mux output is A when s = 0, B when s = 1.
- FSM states are IDLE, SERVE_A and SERVE_B. A 1-bit priority pointer `prio` (0 = A first) and a beat counter `cnt` are kept.
- IDLE:
  - Only reqA high: go to SERVE_A with s = 0.
  - Only reqB high: go to SERVE_B with s = 1.
  - Both high: serve the requester named by prio.
  - Neither high: stay in IDLE.
  - On every exit from IDLE, cnt is cleared to 0.
- Output stage is free when out_valid = 0, or when out_ready = 1.
- In SERVE_X, ackX = reqX AND free. The other requester's ack is 0. In IDLE both acks are 0.
- When a beat is accepted (reqX AND ackX):
  - Out <= mux output.
  - out_valid <= 1.
  - cnt <= cnt + 1.
- Out drain: if out_valid AND out_ready and no beat is accepted in that cycle, then out_valid <= 0 and Out holds its value.
- Burst end happens on an accepted beat when lastX = 1 or cnt + 1 = MAXBURST. On burst end:
  - State goes to IDLE.
  - prio <= the other requester.
- Abandoned burst: if reqX is low in SERVE_X, the state goes to IDLE and prio toggles.
- s changes only on an IDLE exit. It holds its value through IDLE.
- cnt width is 4 bits, compared against MAXBURST. It never wraps, because a burst ends at MAXBURST.
- A simultaneous drain and accept in the same cycle loads the new beat, and out_valid stays 1.
- Requesters must hold data, last and req stable until acked. The arbiter does not check this.

## Timing
- Reset values:
  - state IDLE, prio 0, cnt 0, s 0
  - Out 0, out_valid 0
  - ackA 0, ackB 0
- Reset mid-burst discards any beat held in Out. The reset cycle produces no ack.
- Grant latency: a req first seen in IDLE at edge t puts the FSM in SERVE_X after edge t. The first ackX can be high in cycle t+1, and the beat appears on Out with out_valid after edge t+1.
- Throughput while granted and out_ready = 1: one beat per cycle.
- Switching between requesters costs exactly one IDLE bubble cycle.
- Backpressure: with out_valid = 1 and out_ready = 0, ackX = 0 and Out is stable.

## Test plan
- Reset, then reqA = 1 with A = 4'h3 and lastA = 1, out_ready = 1:
  - ackA high one cycle after req seen.
  - Out = 4'h3, out_valid = 1 on the next cycle.
  - FSM returns to IDLE and prio becomes 1.
- reqA and reqB held high, all beats with last = 1, out_ready = 1: Out alternates A, B, A, B with one bubble between grants, starting with A.
- MAXBURST = 4, reqA held with lastA = 0 and data 1, 2, 3, 4, 5, reqB high:
  - Exactly 4 A beats are accepted.
  - B is then granted; beat 5 of A waits for A's next turn.
- out_ready = 0 after the first beat:
  - ackA stays 0 and Out holds its value.
  - When out_ready = 1, the next beat is loaded in the same cycle the old one drains, and out_valid stays 1.
- Assert reset during the second beat of a B burst: on the next cycle out_valid = 0, s = 0, state IDLE, ackB = 0, prio = 0.
- reqB drops mid-burst: FSM returns to IDLE with no further ackB, and a pending reqA is granted next.

Source files
------------

// File: rtl/rr_arb2_4.sv
// rr_arb2_4: round-robin arbiter/sequencer sharing one 2:1 mux datapath
// between requesters A and B, with a registered valid/ready output stage
// and a per-grant burst cap so neither side can starve the other.
module rr_arb2_4 #(
  parameter int WIDTH    = 4,
  parameter int MAXBURST = 4   // beats per grant, 1..15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             reqA,
  input  logic             lastA,
  input  logic [WIDTH-1:0] A,
  output logic             ackA,
  input  logic             reqB,
  input  logic             lastB,
  input  logic [WIDTH-1:0] B,
  output logic             ackB,
  output logic             s,
  output logic [WIDTH-1:0] Out,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_A = 2'd1,
    SERVE_B = 2'd2
  } state_t;

  localparam logic [3:0] CNT_MAX = 4'(MAXBURST);

  state_t           state;
  logic             prio;      // 0: A wins a tie, 1: B wins a tie
  logic [3:0]       cnt;       // beats accepted in the current grant

  logic             free;
  logic             accept;
  logic             last_sel;
  logic             burst_end;
  logic [3:0]       cnt_inc;
  logic [WIDTH-1:0] mux_out;

  // Shared mux, handshake acks and burst-end detection.
  // NOTE: every always_comb output gets a value on every path (here by
  // unconditional assignment), otherwise synthesis infers a latch.
  always_comb begin
    mux_out   = s ? B : A;
    free      = !out_valid || out_ready;
    // s always names the served requester, so acks can be qualified by state alone.
    ackA      = !reset && (state == SERVE_A) && reqA && free;
    ackB      = !reset && (state == SERVE_B) && reqB && free;
    accept    = ackA || ackB;
    last_sel  = s ? lastB : lastA;
    cnt_inc   = cnt + 4'd1;
    burst_end = accept && (last_sel || (cnt_inc == CNT_MAX));
  end

  // Arbitration FSM together with its registered select, output stage and counters.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      prio      <= 1'b0;
      cnt       <= 4'd0;
      s         <= 1'b0;
      Out       <= '0;
      out_valid <= 1'b0;
    end else begin
      // Output stage: a new beat wins over a drain in the same cycle.
      if (accept) begin
        Out       <= mux_out;
        out_valid <= 1'b1;
        cnt       <= cnt_inc;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (reqA && (!reqB || !prio)) begin
            state <= SERVE_A;
            s     <= 1'b0;
            cnt   <= 4'd0;
          end else if (reqB) begin
            state <= SERVE_B;
            s     <= 1'b1;
            cnt   <= 4'd0;
          end
        end
        SERVE_A: begin
          if (!reqA) begin
            // Requester walked away mid-burst: release the datapath.
            state <= IDLE;
            prio  <= ~prio;
          end else if (burst_end) begin
            state <= IDLE;
            prio  <= 1'b1;
          end
        end
        SERVE_B: begin
          if (!reqB) begin
            state <= IDLE;
            prio  <= ~prio;
          end else if (burst_end) begin
            state <= IDLE;
            prio  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
